fetch_stage: RTL and testbench

//  Instruction-fetch stage plus Fetch/Decode pipeline register, upstream of the hazard unit.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master; the memory (or its model) is the slave.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single-outstanding imem request, redirect handling,
// a one-entry fetch buffer for decode stalls, and the Fetch/Decode pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          StallF,
   input  logic          StallD,
   input  logic          FlushD,
   input  logic          BranchTakenE,
   input  logic [31:0]   ALUResultE,
   input  logic          PCSrcWB,
   input  logic [31:0]   ResultWB,
   fetch_stage_if.master imem,
   output logic [31:0]   InstrD,
   output logic [31:0]   PCPlus8D,
   output logic          ValidD,
   output logic          FetchBusyF
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        fb_valid_q, fb_valid_d;
   logic [31:0] fb_instr_q, fb_instr_d;
   logic [31:0] fb_pc8_q, fb_pc8_d;
   logic        valid_d_q, valid_d_d;
   logic [31:0] instr_d_q, instr_d_d;
   logic [31:0] pc8_d_q, pc8_d_d;

   logic        redirect;
   logic [31:0] target;
   logic        can_issue;
   logic        req_raw;
   logic [31:0] addr_out;
   logic        accept;
   logic [31:0] resp_pc8;

   assign redirect  = BranchTakenE | PCSrcWB;
   assign target    = BranchTakenE ? ALUResultE : ResultWB;
   assign can_issue = ~StallF & ~redirect & ~fb_valid_q;
   assign resp_pc8  = pcf_q + 32'd8;

   // Redirects always win over the memory wait; an abandoned request is finished off in DRAIN.
   always_comb begin
      state_d    = state_q;
      pcf_d      = pcf_q;
      req_addr_d = req_addr_q;
      req_raw    = 1'b0;
      addr_out   = pcf_q;
      accept     = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_raw = can_issue;
            if (redirect) begin
               pcf_d = target;
            end else if (can_issue) begin
               if (imem.imem_ready) begin
                  accept = 1'b1;
                  pcf_d  = pcf_q + 32'd4;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            req_raw = 1'b1;
            if (imem.imem_ready) begin
               state_d = S_IDLE;
               if (redirect) begin
                  pcf_d = target;
               end else begin
                  accept = 1'b1;
                  pcf_d  = pcf_q + 32'd4;
               end
            end else if (redirect) begin
               req_addr_d = pcf_q;
               pcf_d      = target;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            req_raw  = 1'b1;
            addr_out = req_addr_q;
            if (redirect) begin
               pcf_d = target;
            end
            if (imem.imem_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      fb_valid_d = fb_valid_q;
      fb_instr_d = fb_instr_q;
      fb_pc8_d   = fb_pc8_q;
      valid_d_d  = valid_d_q;
      instr_d_d  = instr_d_q;
      pc8_d_d    = pc8_d_q;

      if (FlushD) begin
         valid_d_d = 1'b0;
         instr_d_d = BUBBLE_INSTR;
         pc8_d_d   = 32'd0;
         if (!StallD) begin
            fb_valid_d = 1'b0;
         end
      end else if (StallD) begin
         valid_d_d = valid_d_q;
      end else if (fb_valid_q) begin
         valid_d_d  = 1'b1;
         instr_d_d  = fb_instr_q;
         pc8_d_d    = fb_pc8_q;
         fb_valid_d = 1'b0;
      end else if (accept) begin
         valid_d_d = 1'b1;
         instr_d_d = imem.imem_rdata;
         pc8_d_d   = resp_pc8;
      end else begin
         valid_d_d = 1'b0;
         instr_d_d = BUBBLE_INSTR;
         pc8_d_d   = 32'd0;
      end

      if (redirect) begin
         fb_valid_d = 1'b0;
      end

      // Only reachable with FB empty, so a stalled response never overwrites a parked one.
      if (accept && StallD) begin
         fb_valid_d = 1'b1;
         fb_instr_d = imem.imem_rdata;
         fb_pc8_d   = resp_pc8;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         pcf_q      <= RESET_PC;
         req_addr_q <= RESET_PC;
         fb_valid_q <= 1'b0;
         fb_instr_q <= BUBBLE_INSTR;
         fb_pc8_q   <= 32'd0;
         valid_d_q  <= 1'b0;
         instr_d_q  <= BUBBLE_INSTR;
         pc8_d_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         pcf_q      <= pcf_d;
         req_addr_q <= req_addr_d;
         fb_valid_q <= fb_valid_d;
         fb_instr_q <= fb_instr_d;
         fb_pc8_q   <= fb_pc8_d;
         valid_d_q  <= valid_d_d;
         instr_d_q  <= instr_d_d;
         pc8_d_q    <= pc8_d_d;
      end
   end

   // Request is forced low while reset is held so an in-flight wait is visibly abandoned.
   assign imem.imem_req  = reset_n & req_raw;
   assign imem.imem_addr = addr_out;
   assign InstrD         = instr_d_q;
   assign PCPlus8D       = pc8_d_q;
   assign ValidD         = valid_d_q;
   assign FetchBusyF     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: zero-wait streaming, wait states, redirect/drain,
// decode stall into the fetch buffer, dual redirect with flush, and reset mid-wait.
module tb_fetch_stage;

   logic        clk;
   logic        reset_n;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        BranchTakenE;
   logic [31:0] ALUResultE;
   logic        PCSrcWB;
   logic [31:0] ResultWB;
   logic [31:0] InstrD;
   logic [31:0] PCPlus8D;
   logic        ValidD;
   logic        FetchBusyF;

   int checks_total;
   int checks_passed;

   fetch_stage_if imem_bus ();

   fetch_stage #(
      .RESET_PC     (32'h0000_0000),
      .BUBBLE_INSTR (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .BranchTakenE (BranchTakenE),
      .ALUResultE   (ALUResultE),
      .PCSrcWB      (PCSrcWB),
      .ResultWB     (ResultWB),
      .imem         (imem_bus),
      .InstrD       (InstrD),
      .PCPlus8D     (PCPlus8D),
      .ValidD       (ValidD),
      .FetchBusyF   (FetchBusyF)
   );

   // Memory image: each word encodes its own address so misrouted data is obvious.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hE5A0, a[15:0]};
   endfunction

   assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      else checks_passed++;
   endtask

   task automatic test_reset;
      reset_n               = 1'b0;
      StallF                = 1'b0;
      StallD                = 1'b0;
      FlushD                = 1'b0;
      BranchTakenE          = 1'b0;
      ALUResultE            = 32'd0;
      PCSrcWB               = 1'b0;
      ResultWB              = 32'd0;
      imem_bus.imem_ready   = 1'b0;
      #2;
      checks_total++;
      if (imem_bus.imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_bus.imem_req);
      else checks_passed++;
      checks_total++;
      if (ValidD !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", ValidD);
      else checks_passed++;
      checks_total++;
      if (InstrD !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 00000000", InstrD);
      else checks_passed++;
      checks_total++;
      if (PCPlus8D !== 32'h0) $display("[TB] FAIL reset_pc8: got %h expected 00000000", PCPlus8D);
      else checks_passed++;
      checks_total++;
      if (FetchBusyF !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", FetchBusyF);
      else checks_passed++;
      #10;
      reset_n = 1'b1;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
         $display("[TB] FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=00000000",
                  imem_bus.imem_req, imem_bus.imem_addr);
      else checks_passed++;
   endtask

   task automatic test_zero_wait;
      imem_bus.imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         checks_total++;
         if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'(4 * i))
            $display("[TB] FAIL zw_addr%0d: got req=%b addr=%h expected req=1 addr=%h",
                     i, imem_bus.imem_req, imem_bus.imem_addr, 32'(4 * i));
         else checks_passed++;
         step();
         checks_total++;
         if (ValidD !== 1'b1 || InstrD !== mem_word(32'(4 * i)) || PCPlus8D !== 32'(4 * i + 8))
            $display("[TB] FAIL zw_instr%0d: got v=%b i=%h p=%h expected v=1 i=%h p=%h",
                     i, ValidD, InstrD, PCPlus8D, mem_word(32'(4 * i)), 32'(4 * i + 8));
         else checks_passed++;
      end
   endtask

   task automatic test_wait_states;
      imem_bus.imem_ready = 1'b0;
      settle();
      chk32("ws_addr_c0", imem_bus.imem_addr, 32'h10);
      step();
      settle();
      checks_total++;
      if (ValidD !== 1'b0 || FetchBusyF !== 1'b1 || imem_bus.imem_req !== 1'b1)
         $display("[TB] FAIL ws_c1: got v=%b busy=%b req=%b expected v=0 busy=1 req=1",
                  ValidD, FetchBusyF, imem_bus.imem_req);
      else checks_passed++;
      chk32("ws_addr_c1", imem_bus.imem_addr, 32'h10);
      step();
      settle();
      checks_total++;
      if (ValidD !== 1'b0 || imem_bus.imem_req !== 1'b1)
         $display("[TB] FAIL ws_c2: got v=%b req=%b expected v=0 req=1", ValidD, imem_bus.imem_req);
      else checks_passed++;
      chk32("ws_addr_c2", imem_bus.imem_addr, 32'h10);
      imem_bus.imem_ready = 1'b1;
      step();
      chk32("ws_instr", InstrD, 32'hE5A0_0010);
      chk32("ws_pc8", PCPlus8D, 32'h18);
      checks_total++;
      if (ValidD !== 1'b1 || FetchBusyF !== 1'b0)
         $display("[TB] FAIL ws_done: got v=%b busy=%b expected v=1 busy=0", ValidD, FetchBusyF);
      else checks_passed++;
   endtask

   task automatic test_redirect_drain;
      logic [31:0] addrs [3];
      addrs[0] = 32'h14;
      addrs[1] = 32'h18;
      addrs[2] = 32'h1C;
      imem_bus.imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk32("rd_stream_addr", imem_bus.imem_addr, addrs[i]);
         step();
      end
      imem_bus.imem_ready = 1'b0;
      settle();
      chk32("rd_addr_20", imem_bus.imem_addr, 32'h20);
      step();
      BranchTakenE = 1'b1;
      ALUResultE   = 32'h100;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20)
         $display("[TB] FAIL rd_wait_hold: got req=%b addr=%h expected req=1 addr=00000020",
                  imem_bus.imem_req, imem_bus.imem_addr);
      else checks_passed++;
      step();
      BranchTakenE = 1'b0;
      ALUResultE   = 32'h0;
      settle();
      checks_total++;
      if (FetchBusyF !== 1'b1 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20)
         $display("[TB] FAIL rd_drain: got busy=%b req=%b addr=%h expected busy=1 req=1 addr=00000020",
                  FetchBusyF, imem_bus.imem_req, imem_bus.imem_addr);
      else checks_passed++;
      imem_bus.imem_ready = 1'b1;
      step();
      checks_total++;
      if (ValidD !== 1'b0 || FetchBusyF !== 1'b0)
         $display("[TB] FAIL rd_dropped: got v=%b busy=%b expected v=0 busy=0", ValidD, FetchBusyF);
      else checks_passed++;
      settle();
      chk32("rd_target_addr", imem_bus.imem_addr, 32'h100);
      step();
      chk32("rd_target_instr", InstrD, 32'hE5A0_0100);
      chk32("rd_target_pc8", PCPlus8D, 32'h108);
   endtask

   task automatic test_stall_fb;
      imem_bus.imem_ready = 1'b0;
      settle();
      chk32("fb_addr_104", imem_bus.imem_addr, 32'h104);
      step();
      StallD              = 1'b1;
      StallF              = 1'b1;
      imem_bus.imem_ready = 1'b1;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h104)
         $display("[TB] FAIL fb_wait_req: got req=%b addr=%h expected req=1 addr=00000104",
                  imem_bus.imem_req, imem_bus.imem_addr);
      else checks_passed++;
      step();
      checks_total++;
      if (imem_bus.imem_req !== 1'b0 || ValidD !== 1'b0 || FetchBusyF !== 1'b0)
         $display("[TB] FAIL fb_parked: got req=%b v=%b busy=%b expected req=0 v=0 busy=0",
                  imem_bus.imem_req, ValidD, FetchBusyF);
      else checks_passed++;
      step();
      checks_total++;
      if (imem_bus.imem_req !== 1'b0 || ValidD !== 1'b0)
         $display("[TB] FAIL fb_hold: got req=%b v=%b expected req=0 v=0", imem_bus.imem_req, ValidD);
      else checks_passed++;
      StallD = 1'b0;
      StallF = 1'b0;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b0)
         $display("[TB] FAIL fb_full_noissue: got req=%b expected 0", imem_bus.imem_req);
      else checks_passed++;
      step();
      checks_total++;
      if (ValidD !== 1'b1 || InstrD !== 32'hE5A0_0104 || PCPlus8D !== 32'h10C)
         $display("[TB] FAIL fb_release: got v=%b i=%h p=%h expected v=1 i=e5a00104 p=0000010c",
                  ValidD, InstrD, PCPlus8D);
      else checks_passed++;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h108)
         $display("[TB] FAIL fb_next_issue: got req=%b addr=%h expected req=1 addr=00000108",
                  imem_bus.imem_req, imem_bus.imem_addr);
      else checks_passed++;
      step();
      chk32("fb_next_instr", InstrD, 32'hE5A0_0108);
   endtask

   task automatic test_dual_redirect;
      BranchTakenE = 1'b1;
      ALUResultE   = 32'h200;
      PCSrcWB      = 1'b1;
      ResultWB     = 32'h300;
      FlushD       = 1'b1;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b0)
         $display("[TB] FAIL dr_no_req: got %b expected 0", imem_bus.imem_req);
      else checks_passed++;
      step();
      checks_total++;
      if (ValidD !== 1'b0 || InstrD !== 32'h0)
         $display("[TB] FAIL dr_flush: got v=%b i=%h expected v=0 i=00000000", ValidD, InstrD);
      else checks_passed++;
      BranchTakenE = 1'b0;
      PCSrcWB      = 1'b0;
      FlushD       = 1'b0;
      settle();
      chk32("dr_target", imem_bus.imem_addr, 32'h200);
      step();
      chk32("dr_instr", InstrD, 32'hE5A0_0200);
      chk32("dr_pc8", PCPlus8D, 32'h208);
      StallD = 1'b1;
      StallF = 1'b1;
      FlushD = 1'b1;
      step();
      checks_total++;
      if (ValidD !== 1'b0 || InstrD !== 32'h0)
         $display("[TB] FAIL dr_flush_over_stall: got v=%b i=%h expected v=0 i=00000000", ValidD, InstrD);
      else checks_passed++;
      StallD = 1'b0;
      StallF = 1'b0;
      FlushD = 1'b0;
   endtask

   task automatic test_reset_mid_wait;
      imem_bus.imem_ready = 1'b1;
      settle();
      chk32("rw_addr_204", imem_bus.imem_addr, 32'h204);
      step();
      StallD              = 1'b1;
      imem_bus.imem_ready = 1'b0;
      step();
      checks_total++;
      if (ValidD !== 1'b1 || FetchBusyF !== 1'b1 || InstrD !== 32'hE5A0_0204)
         $display("[TB] FAIL rw_in_wait: got v=%b busy=%b i=%h expected v=1 busy=1 i=e5a00204",
                  ValidD, FetchBusyF, InstrD);
      else checks_passed++;
      reset_n = 1'b0;
      #1;
      checks_total++;
      if (imem_bus.imem_req !== 1'b0 || ValidD !== 1'b0 || FetchBusyF !== 1'b0)
         $display("[TB] FAIL rw_async: got req=%b v=%b busy=%b expected req=0 v=0 busy=0",
                  imem_bus.imem_req, ValidD, FetchBusyF);
      else checks_passed++;
      step();
      reset_n = 1'b1;
      StallD  = 1'b0;
      settle();
      checks_total++;
      if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
         $display("[TB] FAIL rw_restart: got req=%b addr=%h expected req=1 addr=00000000",
                  imem_bus.imem_req, imem_bus.imem_addr);
      else checks_passed++;
      imem_bus.imem_ready = 1'b1;
      step();
      checks_total++;
      if (ValidD !== 1'b1 || InstrD !== 32'hE5A0_0000 || PCPlus8D !== 32'h8)
         $display("[TB] FAIL rw_first_instr: got v=%b i=%h p=%h expected v=1 i=e5a00000 p=00000008",
                  ValidD, InstrD, PCPlus8D);
      else checks_passed++;
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_redirect_drain();
      test_stall_fb();
      test_dual_redirect();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
